// File: rtl/servant_loader_pkg.sv
// rtl/servant_loader_pkg.sv - shared types and constants for the servant UART loader
package servant_loader_pkg;

    typedef enum logic [1:0] {LEN0, LEN1, DATA, DONE} loader_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/servant_uart_rx.sv
// rtl/servant_uart_rx.sv - 8N1 UART receiver with input synchroniser and framing check
module servant_uart_rx #(
    parameter int clk_per_bit = 139
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int CW = $clog2(clk_per_bit);
    localparam logic [CW-1:0] HALF_M1 = CW'(clk_per_bit / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(clk_per_bit - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    rx_state_t      state;
    logic           rx_meta;
    logic           rx_sync;
    logic           rx_prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta     <= i_rx;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) state <= RX_START;
                end
                RX_START: begin
                    // A line that is high again at mid-start-bit was only a glitch.
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                            state   <= RX_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= RX_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (rx_sync) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/servant_uart_loader.sv
// rtl/servant_uart_loader.sv - UART boot loader writing a length-prefixed image into RAM over Wishbone
module servant_uart_loader
    import servant_loader_pkg::*;
#(
    parameter int depth       = 256,
    parameter int aw          = $clog2(depth),
    parameter int clk_per_bit = 139
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rx,
    output logic [aw-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic          i_wb_ack,
    output logic          o_done,
    output logic          o_err
);

    localparam logic [15:0] MAX_WORDS = 16'(depth / WORD_BYTES);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ferr;

    loader_state_t state;
    logic [1:0]    byte_cnt;
    logic [23:0]   word_buf;
    logic [31:0]   hold;
    logic          pending;
    logic [15:0]   len;
    logic [15:0]   word_cnt;
    logic [aw-3:0] idx;

    servant_uart_rx #(.clk_per_bit(clk_per_bit)) u_rx (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx        (i_rx),
        .o_data      (rx_data),
        .o_valid     (rx_valid),
        .o_frame_err (rx_ferr)
    );

    assign o_wb_sel = 4'hF;
    assign o_wb_we  = 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= LEN0;
            byte_cnt <= '0;
            word_buf <= '0;
            hold     <= '0;
            pending  <= 1'b0;
            len      <= '0;
            word_cnt <= '0;
            idx      <= '0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_cyc <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            if (rx_ferr) o_err <= 1'b1;

            // Launch only from an idle bus so cyc is always low the cycle after an ack.
            if (o_wb_cyc) begin
                if (i_wb_ack) begin
                    o_wb_cyc <= 1'b0;
                    idx      <= idx + 1'b1;
                end
            end else if (pending) begin
                o_wb_cyc <= 1'b1;
                o_wb_dat <= hold;
                o_wb_adr <= idx;
                pending  <= 1'b0;
            end

            case (state)
                LEN0: begin
                    if (rx_valid) begin
                        len[7:0] <= rx_data;
                        state    <= LEN1;
                    end
                end
                LEN1: begin
                    if (rx_valid) begin
                        len[15:8] <= rx_data;
                        if ({rx_data, len[7:0]} == 16'd0) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            if ({rx_data, len[7:0]} > MAX_WORDS) o_err <= 1'b1;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_valid && word_cnt != len) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                // Held word still waiting behind a stalled write is lost.
                                if (pending && o_wb_cyc) o_err <= 1'b1;
                                hold     <= {rx_data, word_buf};
                                pending  <= 1'b1;
                                word_cnt <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                    if (o_wb_cyc && i_wb_ack && word_cnt == len && !pending) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
